// File: rtl/c7b_axi_rd_arb.sv
// Round-robin arbiter that funnels NREQ read requesters onto one AXI read port,
// keeping a single read outstanding and steering R beats back to the granted requester.
module c7b_axi_rd_arb #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*8-1:0]      req_len,
    input  logic [NREQ-1:0]        req_cancel,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic                   rsp_fault,
    output logic                   err_pulse,
    output logic [ID_W-1:0]        arid,
    output logic [ADDR_W-1:0]      araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arlock,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [ID_W-1:0]        rid,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready
);

    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W  = 9;
    localparam logic [2:0]  AXSIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;
    logic [PTR_W-1:0]   r_g;
    logic [PTR_W-1:0]   w_g_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [7:0]         r_len;
    logic [7:0]         w_len_nxt;
    logic               r_cancel;
    logic               w_cancel_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [ADDR_W-1:0]  w_addr_arr [NREQ];
    logic [7:0]         w_len_arr  [NREQ];
    logic               w_any;
    logic [PTR_W-1:0]   w_pick;
    int unsigned        w_idx;
    logic [NREQ-1:0]    w_g_onehot;
    logic               w_ar_act;
    logic               w_ar_hs;
    logic               w_beat;
    logic               w_match;
    logic               w_stray;
    logic               w_cancel_now;
    logic               w_fwd;
    logic               w_len_err;
    logic               w_done;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign w_len_arr[i]  = req_len[i*8 +: 8];
    end

    // Round-robin search from r_rr_ptr upward; descending loop lets the nearest requester win.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_idx = (32'(r_rr_ptr) + 32'(k)) % NREQ;
            if (req_valid[PTR_W'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_g_onehot   = NREQ'(1) << r_g;
        w_ar_act     = (r_state == S_AR);
        w_ar_hs      = w_ar_act && arready;
        w_beat       = (r_state == S_R) && rvalid;
        w_match      = w_beat && (rid == ID_W'(r_g));
        w_stray      = w_beat && !w_match;
        w_cancel_now = (r_state != S_IDLE) && req_cancel[r_g];
        // A cancel arriving with a beat already suppresses that beat.
        w_fwd        = w_match && !(r_cancel || w_cancel_now);
        w_len_err    = w_match && ((rlast && (r_cnt != CNT_W'(r_len))) ||
                                   (!rlast && (r_cnt >= CNT_W'(r_len))));
        w_done       = w_match && rlast;
    end

    // AR channel: fields driven from latched grant, zero whenever no address is offered.
    always_comb begin
        arvalid = w_ar_act;
        arid    = w_ar_act ? ID_W'(r_g) : '0;
        araddr  = w_ar_act ? r_addr : '0;
        arlen   = w_ar_act ? r_len : '0;
        arsize  = w_ar_act ? AXSIZE : '0;
        arburst = w_ar_act ? 2'b01 : '0;
        arlock  = 1'b0;
        arcache = '0;
        arprot  = '0;
        req_ack = w_ar_hs ? w_g_onehot : '0;
    end

    // R channel steering back to the granted requester.
    always_comb begin
        rready    = (r_state == S_R);
        rsp_valid = w_fwd ? w_g_onehot : '0;
        rsp_data  = w_fwd ? rdata : '0;
        rsp_last  = w_fwd && rlast;
        rsp_fault = w_fwd && (rresp != 2'b00);
        err_pulse = w_stray || w_len_err;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_g_nxt      = r_g;
        w_addr_nxt   = r_addr;
        w_len_nxt    = r_len;
        w_cancel_nxt = r_cancel;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cancel_nxt = 1'b0;
                w_cnt_nxt    = '0;
                if (w_any) begin
                    w_g_nxt     = w_pick;
                    w_addr_nxt  = w_addr_arr[w_pick];
                    w_len_nxt   = w_len_arr[w_pick];
                    w_state_nxt = S_AR;
                end
            end
            S_AR: begin
                if (w_cancel_now) begin
                    w_cancel_nxt = 1'b1;
                end
                if (arready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                if (w_cancel_now) begin
                    w_cancel_nxt = 1'b1;
                end
                // Saturate so a runaway slave keeps flagging errors instead of wrapping.
                if (w_match && (r_cnt != '1)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (w_done) begin
                    w_state_nxt  = S_IDLE;
                    w_cancel_nxt = 1'b0;
                    w_rr_ptr_nxt = (r_g == PTR_W'(NREQ - 1)) ? '0 : r_g + PTR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_g      <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cancel <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_g      <= w_g_nxt;
            r_addr   <= w_addr_nxt;
            r_len    <= w_len_nxt;
            r_cancel <= w_cancel_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_c7b_axi_rd_arb.sv
// Scoreboard bench for c7b_axi_rd_arb: the bench plays requesters and AXI slave,
// a reference model predicts AR grants, forwarded beats and error pulses.
`timescale 1ns/1ps
module tb_c7b_axi_rd_arb;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*8-1:0]      req_len = '0;
    logic [NREQ-1:0]        req_cancel = '0;
    logic [NREQ-1:0]        req_ack;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_last;
    logic                   rsp_fault;
    logic                   err_pulse;
    logic [ID_W-1:0]        arid;
    logic [ADDR_W-1:0]      araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arlock;
    logic [3:0]             arcache;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready = 1'b0;
    logic [ID_W-1:0]        rid = '0;
    logic [DATA_W-1:0]      rdata = '0;
    logic [1:0]             rresp = '0;
    logic                   rlast = 1'b0;
    logic                   rvalid = 1'b0;
    logic                   rready;

    always #5 clk = ~clk;

    c7b_axi_rd_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_cancel(req_cancel),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_fault(rsp_fault), .err_pulse(err_pulse),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {int id; logic [ADDR_W-1:0] addr; int len;} ar_t;
    typedef struct {int id; logic [DATA_W-1:0] data; bit last; bit fault;} rsp_t;

    ar_t  ar_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad = 0;
    int   err_seen = 0;
    int   err_exp = 0;

    // Reference model state: pending requests and the round-robin pointer.
    logic [NREQ-1:0]   pend = '0;
    int                m_rr = 0;
    logic [ADDR_W-1:0] m_addr [NREQ];
    int                m_len [NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s bound expired t=%0t", nm, $time);
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int pick_grant();
        for (int k = 0; k < int'(NREQ); k++) begin
            if (pend[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic add_req(input int i, input logic [ADDR_W-1:0] a, input int l);
        if (!pend[i]) begin
            pend[i]   = 1'b1;
            m_addr[i] = a;
            m_len[i]  = l;
        end
    endtask

    task automatic drive_req();
        req_valid = pend;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = m_addr[i];
            req_len[i*8 +: 8]            = 8'(m_len[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks AR presentation and pops forwarded beats against the scoreboard.
    ar_t  mon_a;
    rsp_t mon_r;
    always @(negedge clk) begin
        if (!reset) begin
            if (arvalid) begin
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected", 64'(arvalid), 64'(0));
                end else begin
                    mon_a = ar_q[0];
                    chk("arid", 64'(arid), 64'(mon_a.id));
                    chk("araddr", 64'(araddr), 64'(mon_a.addr));
                    chk("arlen", 64'(arlen), 64'(mon_a.len));
                    chk("ar_attr", 64'({arsize, arburst, arlock, arcache, arprot}),
                        64'({3'd3, 2'b01, 1'b0, 4'd0, 3'd0}));
                    if (arready) begin
                        chk("req_ack_hs", 64'(req_ack), 64'(onehot(mon_a.id)));
                        ar_q.delete(0);
                    end else begin
                        chk("req_ack_stall", 64'(req_ack), 64'(0));
                    end
                end
            end else begin
                chk("req_ack_idle", 64'(req_ack), 64'(0));
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(onehot(mon_r.id)));
                    chk("rsp_data", 64'(rsp_data), 64'(mon_r.data));
                    chk("rsp_last_fault", 64'({rsp_last, rsp_fault}), 64'({mon_r.last, mon_r.fault}));
                end
            end else begin
                chk("rsp_quiet", 64'({rsp_data != '0, rsp_last, rsp_fault}), 64'(0));
            end
            if (err_pulse) err_seen++;
        end
    end

    // One full transaction. stall: cycles of arready low; cancel_at: -1 none, -2 during AR,
    // else matching beat index; stray_mode: 0 none, 1 random, 2 one rid=2 beat first;
    // len_mode: 0 correct rlast, 1 early rlast, 2 late rlast.
    task automatic run_txn(input int stall, input int cancel_at, input int stray_mode,
                           input bit fault0, input logic [DATA_W-1:0] dbase, input int len_mode);
        int g, len, n, cnt, end_idx, guard;
        bit hs, cflag, done, last, stray_done;
        logic [1:0] rr;
        logic [DATA_W-1:0] d;
        logic [ID_W-1:0] sr;
        g   = pick_grant();
        len = m_len[g];
        ar_q.push_back('{g, m_addr[g], len});
        drive_req();
        req_cancel = NREQ'($urandom);
        rvalid = 1'b1; rid = ID_W'(g); rlast = 1'b1; rdata = {$urandom, $urandom};
        cflag = 1'b0; hs = 1'b0; n = 0;
        while (!hs) begin
            tick();
            n++;
            arready    = (n > stall);
            req_cancel = NREQ'($urandom) & ~onehot(g);
            if (cancel_at == -2 && n == 1) begin
                req_cancel[g] = 1'b1;
                cflag = 1'b1;
            end
            rvalid = 1'($urandom_range(0, 1)); rid = ID_W'(g); rlast = 1'b1;
            rdata  = {$urandom, $urandom};
            @(negedge clk);
            chk("rready_ar", 64'(rready), 64'(0));
            if (n == 1) chk("ar_latency", 64'(arvalid), 64'(1));
            if (arvalid && arready) hs = 1'b1;
            else if (n > 64) begin
                fail_now("ar_timeout");
                return;
            end
        end
        pend[g] = 1'b0;
        end_idx = len;
        if (len_mode == 1 && len > 0) end_idx = $urandom_range(0, len - 1);
        if (len_mode == 2) end_idx = len + $urandom_range(1, 2);
        cnt = 0; done = 1'b0; guard = 0; stray_done = 1'b0;
        while (!done) begin
            tick();
            arready = 1'b0;
            drive_req();
            req_cancel = NREQ'($urandom) & ~onehot(g);
            rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
            guard++;
            if (guard > 200) begin
                fail_now("r_guard");
                return;
            end
            if (stray_mode == 2 && !stray_done) begin
                stray_done = 1'b1;
                rvalid = 1'b1; rid = ID_W'(2); rdata = {$urandom, $urandom}; rlast = 1'b1;
                err_exp++;
            end else if (stray_mode == 1 && $urandom_range(0, 4) == 0) begin
                do sr = ID_W'($urandom); while (sr == ID_W'(g));
                rvalid = 1'b1; rid = sr; rdata = {$urandom, $urandom};
                rlast = 1'($urandom_range(0, 1)); rresp = 2'($urandom);
                err_exp++;
            end else if ($urandom_range(0, 3) != 0) begin
                d    = (dbase != '0) ? dbase + DATA_W'(cnt) : {$urandom, $urandom};
                rr   = (fault0 && cnt == 0) ? 2'b10 :
                       (($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00);
                last = (cnt == end_idx);
                if (cancel_at == cnt) begin
                    req_cancel[g] = 1'b1;
                    cflag = 1'b1;
                end
                rvalid = 1'b1; rid = ID_W'(g); rdata = d; rresp = rr; rlast = last;
                if ((last && cnt != len) || (!last && cnt >= len)) err_exp++;
                if (!cflag) rsp_q.push_back('{g, d, last, rr != 2'b00});
                cnt++;
                done = last;
            end
        end
        tick();
        rvalid = 1'b0; req_cancel = '0; rlast = 1'b0;
        m_rr = (g + 1) % NREQ;
        @(negedge clk);
        chk("scoreboard_drained", 64'(ar_q.size() + rsp_q.size()), 64'(0));
        chk("err_count", 64'(err_seen), 64'(err_exp));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({arvalid, rready, req_ack, rsp_valid, err_pulse, rsp_last, rsp_fault,
                              arburst, arsize, arlock, arcache, arprot}), 64'(0));
        chk({nm, "_ar"}, 64'({arid, araddr, arlen}), 64'(0));
        chk({nm, "_data"}, 64'(rsp_data), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        for (int i = 0; i < int'(NREQ); i++) begin
            m_addr[i] = '0;
            m_len[i]  = 0;
        end
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("reset_state");
        tick();
        reset = 1'b0;

        // All requesters held with single-beat reads: expect grants 0,1,2,0.
        for (int i = 0; i < int'(NREQ); i++) add_req(i, ADDR_W'(32'h100 * (i + 1)), 0);
        for (int t = 0; t < 4; t++) begin
            run_txn(0, -1, 0, 1'b0, '0, 0);
            if (t < 3) for (int i = 0; i < int'(NREQ); i++) add_req(i, ADDR_W'(32'h100 * (i + 1)), 0);
        end

        // Four-beat read from requester 1 with known data.
        pend = '0;
        add_req(1, 32'h1000, 3);
        run_txn(0, -1, 0, 1'b0, 64'hA, 0);

        // AR held off by arready low for five cycles.
        pend = '0;
        add_req(2, 32'h2468, 2);
        run_txn(5, -1, 0, 1'b0, '0, 0);

        // Cancel after beat 1, then a normal read.
        pend = '0;
        add_req(0, 32'h3000, 3);
        run_txn(0, 2, 0, 1'b0, '0, 0);
        add_req(1, 32'h3100, 1);
        run_txn(0, -1, 0, 1'b0, '0, 0);

        // Cancel while AR is stalled.
        add_req(2, 32'h3200, 2);
        run_txn(2, -2, 0, 1'b0, '0, 0);

        // Fault on beat 0 and a stray rid=2 beat while requester 0 is granted.
        pend = '0;
        add_req(0, 32'h5000, 1);
        run_txn(0, -1, 2, 1'b1, '0, 0);

        // Early and late rlast.
        add_req(1, 32'h5100, 3);
        run_txn(0, -1, 0, 1'b0, '0, 1);
        add_req(2, 32'h5200, 1);
        run_txn(0, -1, 0, 1'b0, '0, 2);

        // Reset in the middle of a read.
        pend = '0;
        add_req(0, 32'h6000, 3);
        add_req(2, 32'h6200, 3);
        g = pick_grant();
        ar_q.push_back('{g, m_addr[g], m_len[g]});
        drive_req();
        tick();
        arready = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            tick();
            arready = 1'b0;
            pend[g] = 1'b0;
            drive_req();
            rvalid = 1'b1; rid = ID_W'(g); rdata = {$urandom, $urandom}; rresp = 2'b00; rlast = 1'b0;
            rsp_q.push_back('{g, rdata, 1'b0, 1'b0});
        end
        tick();
        rvalid = 1'b0;
        reset  = 1'b1;
        pend   = '0;
        add_req(2, 32'h7000, 2);
        drive_req();
        tick();
        @(negedge clk);
        chk_all_zero("reset_mid_read");
        chk("reset_mid_sb", 64'(ar_q.size() + rsp_q.size()), 64'(0));
        ar_q.delete();
        rsp_q.delete();
        m_rr = 0;
        tick();
        reset = 1'b0;
        run_txn(0, -1, 0, 1'b0, '0, 0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            int cm, sm, lm;
            for (int i = 0; i < int'(NREQ); i++) begin
                if ($urandom_range(0, 2) == 0) add_req(i, ADDR_W'($urandom), $urandom_range(0, 4));
            end
            if (pend == '0) add_req($urandom_range(0, NREQ - 1), ADDR_W'($urandom), $urandom_range(0, 4));
            g  = pick_grant();
            cm = $urandom_range(0, 5);
            cm = (cm == 0) ? -2 : (cm == 1) ? $urandom_range(0, m_len[g]) : -1;
            sm = $urandom_range(0, 1);
            lm = $urandom_range(0, 9);
            lm = (lm == 0) ? 1 : (lm == 1) ? 2 : 0;
            run_txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, cm, sm,
                    1'($urandom_range(0, 1)), '0, lm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
